// File: rtl/gate_identifier_pkg.sv
// Shared definitions for the two-input gate tester: FSM encodings, gate codes
// and the canonical truth-table patterns indexed by {a,b}.
package gate_identifier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam logic [2:0] GATE_NONE = 3'd0;
    localparam logic [2:0] GATE_AND  = 3'd1;
    localparam logic [2:0] GATE_OR   = 3'd2;
    localparam logic [2:0] GATE_XOR  = 3'd3;
    localparam logic [2:0] GATE_NAND = 3'd4;
    localparam logic [2:0] GATE_NOR  = 3'd5;
    localparam logic [2:0] GATE_XNOR = 3'd6;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // Exact-match lookup; any pattern outside the library maps to GATE_NONE.
    function automatic logic [2:0] tt_to_code(input logic [3:0] tt);
        logic [2:0] code;
        case (tt)
            TT_AND:  code = GATE_AND;
            TT_OR:   code = GATE_OR;
            TT_XOR:  code = GATE_XOR;
            TT_NAND: code = GATE_NAND;
            TT_NOR:  code = GATE_NOR;
            TT_XNOR: code = GATE_XNOR;
            default: code = GATE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/gate_identifier_tt_decode.sv
// Combinational truth-table classifier: 4-bit table -> gate code and match flag.
module gate_tt_decode
    import gate_identifier_pkg::*;
(
    input  logic [3:0] tt_i,
    output logic [2:0] code_o,
    output logic       match_o
);

    // Pure lookup so any future checker can reuse the same classification.
    always_comb begin
        code_o  = tt_to_code(tt_i);
        match_o = (code_o != GATE_NONE);
    end

endmodule

// File: rtl/gate_identifier.sv
// Sequential tester: walks {a,b} through 00..11, samples y_in after a settle
// delay and reports the truth table plus the decoded gate identity.
module gate_identifier
    import gate_identifier_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_tbl,
    output logic [2:0] gate_code,
    output logic       match
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] work_q, work_d;
    logic [3:0] tt_q, tt_d;
    logic [2:0] code_q, code_d;
    logic       match_q, match_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] tt_final_s;
    logic [2:0] code_final_s;
    logic       match_final_s;

    // The last vector's sample goes straight into the table without a work slot.
    assign tt_final_s = {y_in, work_q};

    gate_tt_decode u_decode (
        .tt_i    (tt_final_s),
        .code_o  (code_final_s),
        .match_o (match_final_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_APPLY;
                else       state_d = ST_IDLE;
            end
            ST_APPLY: begin
                if ((cnt_q == 8'd0) && (idx_q == 2'd3)) state_d = ST_REPORT;
                else                                   state_d = ST_APPLY;
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Vector index, settle counter, sample capture and result latching.
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        tt_d    = tt_q;
        code_d  = code_q;
        match_d = match_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d = 2'd0;
                    cnt_d = SETTLE_INIT;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_APPLY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    case (idx_q)
                        2'd0:    work_d[0] = y_in;
                        2'd1:    work_d[1] = y_in;
                        2'd2:    work_d[2] = y_in;
                        default: work_d    = work_q;
                    endcase
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = SETTLE_INIT;
                    end else begin
                        tt_d    = tt_final_s;
                        code_d  = code_final_s;
                        match_d = match_final_s;
                    end
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Output logic, computed from the next state so the ports are registered.
    always_comb begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_REPORT);
        if (state_d == ST_APPLY) begin
            a_d = idx_d[1];
            b_d = idx_d[0];
        end else begin
            a_d = 1'b0;
            b_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            work_q  <= 3'd0;
            tt_q    <= 4'd0;
            code_q  <= GATE_NONE;
            match_q <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            tt_q    <= tt_d;
            code_q  <= code_d;
            match_q <= match_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign truth_tbl = tt_q;
    assign gate_code = code_q;
    assign match     = match_q;

endmodule

// File: tb/tb_gate_identifier.sv
// Scoreboard bench for gate_identifier: settle-2 instance with a registered
// gate model, settle-0 instance with a combinational XOR.
module tb_gate_identifier;

    typedef struct {
        logic [3:0] tt;
        logic [2:0] code;
        logic       m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       y_r = 1'b0;
    logic       a_out, b_out, busy, done, match;
    logic [3:0] truth_tbl;
    logic [2:0] gate_code;

    logic       start0 = 1'b0;
    logic       y0;
    logic       a0, b0, busy0, done0, match0;
    logic [3:0] tt0;
    logic [2:0] code0;

    int   mode = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];

    // Modes 0..5: AND OR XOR NAND NOR XNOR; 6: tied 0; 7: tied 1.
    logic [2:0] code_tab [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};

    gate_identifier #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_r),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done),
        .truth_tbl(truth_tbl), .gate_code(gate_code), .match(match)
    );

    gate_identifier #(.SETTLE_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0),
        .truth_tbl(tt0), .gate_code(code0), .match(match0)
    );

    always #5 clk = ~clk;

    function automatic logic gate_f(input int m, input logic a, input logic b);
        case (m)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) y_r <= gate_f(mode, a_out, b_out);
    assign y0 = a0 ^ b0;
    always @(negedge clk) if (done) done_cnt++;

    task automatic push_exp(input int m);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = i[1:0];
            e.tt[i] = gate_f(m, v[1], v[0]);
        end
        e.code = code_tab[m];
        e.m    = (code_tab[m] != 3'd0);
        sb_q.push_back(e);
    endtask

    task automatic launch(input int m);
        mode = m;
        push_exp(m);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_out, b_out, busy, done, truth_tbl, gate_code, match} !== 11'd0) begin
            failures++;
            $display("FAIL reset_dut got=%b want=0", {a_out, b_out, busy, done, truth_tbl, gate_code, match});
        end
        checks++;
        if ({a0, b0, busy0, done0, tt0, code0, match0} !== 11'd0) begin
            failures++;
            $display("FAIL reset_dut0 got=%b want=0", {a0, b0, busy0, done0, tt0, code0, match0});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gates(input int first, input int last);
        int n;
        bit ok;
        exp_t e;
        for (int m = first; m <= last; m++) begin
            launch(m);
            wait_done(n, ok);
            checks++;
            if (!ok || n != 12) begin
                failures++;
                $display("FAIL latency_m%0d got=%0d want=12 seen=%0d", m, n, ok);
            end
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_empty_m%0d got=0 want=1", m);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (truth_tbl !== e.tt || gate_code !== e.code || match !== e.m) begin
                    failures++;
                    $display("FAIL result_m%0d got=%b/%0d/%b want=%b/%0d/%b", m,
                             truth_tbl, gate_code, match, e.tt, e.code, e.m);
                end
            end
            checks++;
            if (busy !== 1'b1 || a_out !== 1'b0 || b_out !== 1'b0) begin
                failures++;
                $display("FAIL report_outs_m%0d got=%b%b%b want=100", m, busy, a_out, b_out);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL back_idle_m%0d got=%b%b want=00", m, busy, done);
            end
        end
    endtask

    task automatic test_busy_start();
        int n, pre;
        bit ok;
        exp_t e;
        pre = done_cnt;
        launch(2);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (truth_tbl !== 4'b1111 || gate_code !== 3'd0) begin
            failures++;
            $display("FAIL hold_during_run got=%b/%0d want=1111/0", truth_tbl, gate_code);
        end
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(n, ok);
        checks++;
        if (!ok || n != 7) begin
            failures++;
            $display("FAIL no_restart got=%0d want=7 seen=%0d", n, ok);
        end
        e = sb_q.pop_front();
        checks++;
        if (truth_tbl !== e.tt || gate_code !== e.code || match !== e.m) begin
            failures++;
            $display("FAIL busy_result got=%b/%0d/%b want=%b/%0d/%b",
                     truth_tbl, gate_code, match, e.tt, e.code, e.m);
        end
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (20) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (busy !== 1'b0 || done_cnt - pre != 1) begin
            failures++;
            $display("FAIL report_start_ignored got=busy%b dones%0d want=busy0 dones1", busy, done_cnt - pre);
        end
        checks++;
        if (truth_tbl !== 4'b0110 || gate_code !== 3'd3 || match !== 1'b1) begin
            failures++;
            $display("FAIL result_hold got=%b/%0d/%b want=0110/3/1", truth_tbl, gate_code, match);
        end
    endtask

    task automatic test_abort();
        int pre;
        pre = done_cnt;
        launch(0);
        repeat (7) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (a_out !== 1'b1 || b_out !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_abort_vec got=%b%b%b want=101", a_out, b_out, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out, b_out, busy, done, truth_tbl, gate_code, match} !== 11'd0) begin
            failures++;
            $display("FAIL abort_outs got=%b want=0", {a_out, b_out, busy, done, truth_tbl, gate_code, match});
        end
        @(negedge clk) rst_n = 1'b1;
        void'(sb_q.pop_back());
        repeat (20) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (done_cnt != pre || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=dones%0d busy%b want=dones0 busy0", done_cnt - pre, busy);
        end
        test_gates(0, 0);
    endtask

    task automatic test_settle0();
        int n;
        exp_t e;
        mode = 2;
        push_exp(2);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        n = 0;
        checks++;
        if ({a0, b0} !== 2'd0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL s0_vec0 got=%b%b busy%b want=00 busy1", a0, b0, busy0);
        end
        for (int v = 1; v < 4; v++) begin
            logic [1:0] want;
            want = v[1:0];
            @(posedge clk); @(negedge clk);
            n++;
            checks++;
            if ({a0, b0} !== want) begin
                failures++;
                $display("FAIL s0_vec%0d got=%b%b want=%b", v, a0, b0, want);
            end
        end
        @(posedge clk); @(negedge clk);
        n++;
        checks++;
        if (done0 !== 1'b1 || n != 4) begin
            failures++;
            $display("FAIL s0_done got=%b after %0d want=1 after 4", done0, n);
        end
        e = sb_q.pop_front();
        checks++;
        if (tt0 !== e.tt || code0 !== e.code || match0 !== e.m) begin
            failures++;
            $display("FAIL s0_result got=%b/%0d/%b want=%b/%0d/%b", tt0, code0, match0, e.tt, e.code, e.m);
        end
    endtask

    initial begin
        test_reset();
        test_gates(0, 0);
        test_gates(1, 5);
        test_gates(6, 7);
        test_busy_start();
        test_abort();
        test_settle0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
